// File: rtl/bcd_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner for a 0..15 value, with load/ack capture.
// Define LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module bcd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] v_in,
  input  logic       load,
  output logic       ack,
  output logic       z,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       disp_valid
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DIG_LD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(BLANK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DIG0,
    GAP0,
    DIG1,
    GAP1
  } state_t;

  state_t        state;
  state_t        ns;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ncnt;
  logic [3:0]    pend_val;
  logic          pend_flag;
  logic [3:0]    disp_val;
  logic          xfer;
  logic [3:0]    nd;
  logic          tens;
  logic [3:0]    ones;
  logic [1:0]    an_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Transfers only happen when entering DIG0, so a digit pair never mixes values.
  always_comb begin
    ns   = state;
    ncnt = cnt;
    xfer = 1'b0;
    case (state)
      IDLE: begin
        if (pend_flag) begin
          ns   = DIG0;
          ncnt = DIG_LD;
          xfer = 1'b1;
        end
      end
      DIG0: begin
        if (cnt == '0) begin
          ns   = GAP0;
          ncnt = GAP_LD;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      GAP0: begin
        if (cnt == '0) begin
          ns   = DIG1;
          ncnt = DIG_LD;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      DIG1: begin
        if (cnt == '0) begin
          ns   = GAP1;
          ncnt = GAP_LD;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      GAP1: begin
        if (cnt == '0) begin
          ns   = DIG0;
          ncnt = DIG_LD;
          xfer = pend_flag;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      default: begin
        ns   = IDLE;
        ncnt = '0;
      end
    endcase
  end

  always_comb begin
    nd    = xfer ? pend_val : disp_val;
    tens  = (nd >= 4'd10);
    ones  = tens ? (nd - 4'd10) : nd;
    an_d  = 2'b11;
    seg_d = 7'h7F;
    case (ns)
      DIG0: begin
        an_d  = 2'b10;
        seg_d = enc(ones);
      end
      DIG1: begin
        an_d  = 2'b01;
        seg_d = enc({3'b000, tens});
`ifdef LEADING_ZERO_BLANK_EN
        if (!tens) begin
          an_d  = 2'b11;
          seg_d = 7'h7F;
        end
`endif
      end
      default: begin
        an_d  = 2'b11;
        seg_d = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_val   <= '0;
      pend_flag  <= 1'b0;
      disp_val   <= '0;
      ack        <= 1'b0;
      z          <= 1'b0;
      an         <= 2'b11;
      seg        <= 7'h7F;
      disp_valid <= 1'b0;
    end else begin
      state      <= ns;
      cnt        <= ncnt;
      pend_flag  <= (pend_flag & ~xfer) | load;
      if (load) begin
        pend_val <= v_in;
      end
      disp_val   <= nd;
      ack        <= load;
      z          <= tens;
      an         <= an_d;
      seg        <= seg_d;
      disp_valid <= disp_valid | xfer;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed steps plus random loads,
// compared against a frame-position reference model.
module tb_bcd_scan_ctrl;

  localparam int R = 4;
  localparam int B = 2;
  localparam int P = 2 * R + 2 * B;

  logic       clk;
  logic       reset;
  logic [3:0] v_in;
  logic       load;
  logic       ack;
  logic       z;
  logic [1:0] an;
  logic [6:0] seg;
  logic       disp_valid;

  int ncmp;
  int nfail;

  bit m_run;
  int m_pos;
  int m_pend;
  bit m_flag;
  int m_disp;
  bit m_valid;
  bit m_ack;

  logic [6:0] enc_t [10];

  bcd_scan_ctrl #(
    .REFRESH_DIV(R),
    .BLANK_CYC  (B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .v_in      (v_in),
    .load      (load),
    .ack       (ack),
    .z         (z),
    .an        (an),
    .seg       (seg),
    .disp_valid(disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp_v);
    ncmp++;
    assert (obs === exp_v)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock of the reference: a frame is P cycles long, position 0 is DIG0.
  task automatic model(input bit l, input int v, input bit r);
    bit tr;
    tr = 1'b0;
    if (r) begin
      m_run   = 1'b0;
      m_pos   = 0;
      m_pend  = 0;
      m_flag  = 1'b0;
      m_disp  = 0;
      m_valid = 1'b0;
      m_ack   = 1'b0;
    end else begin
      if (!m_run) begin
        if (m_flag) begin
          m_run = 1'b1;
          m_pos = 0;
          tr    = 1'b1;
        end
      end else begin
        m_pos = m_pos + 1;
        if (m_pos == P) begin
          m_pos = 0;
          tr    = m_flag;
        end
      end
      if (tr) begin
        m_disp  = m_pend;
        m_flag  = 1'b0;
        m_valid = 1'b1;
      end
      if (l) begin
        m_pend = v;
        m_flag = 1'b1;
      end
      m_ack = l;
    end
  endtask

  task automatic check_all();
    logic [1:0] ea;
    logic [6:0] es;
    int         ones;
    bit         tens;
    tens = (m_disp >= 10);
    ones = tens ? m_disp - 10 : m_disp;
    ea   = 2'b11;
    es   = 7'h7F;
    if (m_run && m_pos < R) begin
      ea = 2'b10;
      es = enc_t[ones];
    end else if (m_run && m_pos >= R + B && m_pos < 2 * R + B) begin
      ea = 2'b01;
      es = tens ? enc_t[1] : enc_t[0];
`ifdef LEADING_ZERO_BLANK_EN
      if (!tens) begin
        ea = 2'b11;
        es = 7'h7F;
      end
`endif
    end
    chk("an", 7'(an), 7'(ea));
    chk("seg", seg, es);
    chk("z", 7'(z), 7'(tens));
    chk("ack", 7'(ack), 7'(m_ack));
    chk("disp_valid", 7'(disp_valid), 7'(m_valid));
  endtask

  task automatic step(input bit l, input int v, input bit r);
    load  = l;
    v_in  = 4'(v);
    reset = r;
    @(posedge clk);
    model(l, v, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int tgt, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_run && m_pos == tgt) break;
      step(1'b0, 0, 1'b0);
    end
    ncmp++;
    assert (m_run && m_pos == tgt)
    else begin
      nfail++;
      $error("FAIL wait_pos observed=%0d expected=%0d", m_pos, tgt);
    end
  endtask

  initial begin
    int acks;
    bit seen12;
    ncmp  = 0;
    nfail = 0;
    enc_t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    m_run = 1'b0; m_pos = 0; m_pend = 0; m_flag = 1'b0;
    m_disp = 0; m_valid = 1'b0; m_ack = 1'b0;
    load  = 1'b0;
    v_in  = '0;
    reset = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0);

    // single load of 7
    step(1'b1, 7, 1'b0);
    chk("ack_pulse", 7'(ack), 7'd1);
    step(1'b0, 0, 1'b0);
    chk("ack_once", 7'(ack), 7'd0);
    chk("dig0_seven", seg, 7'h78);
    for (int i = 0; i < 2 * P; i++) step(1'b0, 0, 1'b0);

    // tens value 13
    step(1'b1, 13, 1'b0);
    run_until(0, 3 * P);
    chk("z_13", 7'(z), 7'd1);
    chk("dig0_13", seg, 7'h30);
    run_until(R + B, 3 * P);
    chk("dig1_13", seg, 7'h79);

    // mid-scan update: 3 shown, then 12 and 15 loaded during DIG1
    step(1'b1, 3, 1'b0);
    run_until(0, 3 * P);
    run_until(R + B, 3 * P);
    acks   = 0;
    seen12 = 1'b0;
    step(1'b1, 12, 1'b0);
    acks += int'(ack);
    step(1'b1, 15, 1'b0);
    acks += int'(ack);
    for (int i = 0; i < 2 * P; i++) begin
      step(1'b0, 0, 1'b0);
      acks += int'(ack);
      if (an == 2'b10 && seg == enc_t[2]) seen12 = 1'b1;
    end
    chk("two_acks", 7'(acks), 7'd2);
    chk("never_12", 7'(seen12), 7'd0);

    // coincident load and transfer
    run_until(P - 2, 3 * P);
    step(1'b1, 4, 1'b0);
    step(1'b1, 9, 1'b0);
    chk("coinc_dig0", seg, enc_t[4]);
    for (int i = 0; i < P; i++) step(1'b0, 0, 1'b0);
    chk("coinc_next", seg, enc_t[9]);
    for (int i = 0; i < P; i++) step(1'b0, 0, 1'b0);

    // reset mid-scan with a pending load
    run_until(1, 3 * P);
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b1);
    chk("rst_an", 7'(an), 7'(2'b11));
    chk("rst_valid", 7'(disp_valid), 7'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0);
    chk("rst_idle", 7'(an), 7'(2'b11));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit l;
      r = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 5) == 0);
      step(l, int'($urandom_range(0, 15)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
